// File: rtl/fft_pkg.sv
// Shared types for the FFT stream framer: write-FSM states, the FIFO entry
// layout and the frame-length clamp.
package fft_pkg;

  // Sample width carried by a FIFO entry; the framer's DATA_WIDTH must equal it.
  localparam int FFT_DATA_WIDTH = 14;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } wr_state_e;

  typedef struct packed {
    logic                             sop;
    logic                             eop;
    logic signed [FFT_DATA_WIDTH-1:0] re;
    logic signed [FFT_DATA_WIDTH-1:0] im;
  } fifo_entry_t;

  localparam int ENTRY_WIDTH = $bits(fifo_entry_t);

  // Keep a requested frame exponent inside the supported range.
  function automatic int clamp_pow(input int pow, input int pow_min, input int pow_max);
    if (pow < pow_min) return pow_min;
    if (pow > pow_max) return pow_max;
    return pow;
  endfunction

endpackage

// File: rtl/fft_stream_fifo.sv
// Synchronous FIFO with combinational head read. A write while full is
// allowed only when a read happens in the same cycle.
module fft_stream_fifo #(
  parameter int WIDTH     = 30,
  parameter int DEPTH_POW = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic                 rd_en,
  output logic [WIDTH-1:0]     rd_data,
  output logic                 full,
  output logic                 empty,
  output logic [DEPTH_POW:0]   count
);

  localparam int DEPTH = 1 << DEPTH_POW;

  logic [WIDTH-1:0]     mem_q [DEPTH];
  logic [DEPTH_POW-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_POW-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_POW:0]   count_q, count_d;
  logic                 do_wr, do_rd;

  // Qualify the requests and advance pointers and occupancy.
  always_comb begin
    do_rd    = rd_en && (count_q != '0);
    do_wr    = wr_en && ((count_q != (DEPTH_POW+1)'(DEPTH)) || do_rd);
    wr_ptr_d = wr_ptr_q + DEPTH_POW'(do_wr);
    rd_ptr_d = rd_ptr_q + DEPTH_POW'(do_rd);
    count_d  = count_q;
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written, so it has no reset.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign full    = (count_q == (DEPTH_POW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;

endmodule

// File: rtl/fft_stream_framer.sv
// Frames a free-running complex sample stream into 2**L-sample packets with
// sop/eop, buffers them through a FIFO so the FFT sink may stall, and reports
// dropped samples. Path: input register -> FIFO -> Avalon-ST output register.
module fft_stream_framer
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = FFT_DATA_WIDTH,
  parameter int POW_MIN    = 6,
  parameter int POW_MAX    = 12,
  parameter int FIFO_POW   = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          aclr,
  input  logic                          enable,
  input  logic [$clog2(POW_MAX+1)-1:0]  len_pow,
  input  logic                          sink_valid,
  input  logic signed [DATA_WIDTH-1:0]  sink_Re,
  input  logic signed [DATA_WIDTH-1:0]  sink_Im,
  input  logic                          source_ready,
  output logic                          source_valid,
  output logic                          source_sop,
  output logic                          source_eop,
  output logic signed [DATA_WIDTH-1:0]  source_Re,
  output logic signed [DATA_WIDTH-1:0]  source_Im,
  output logic                          busy,
  output logic                          error,
  output logic                          overflow,
  output logic [CNT_WIDTH-1:0]          frame_count
);

  localparam int LEN_W = $clog2(POW_MAX+1);
  localparam int DEPTH = 1 << FIFO_POW;

  wr_state_e            state_q, state_d;
  logic [POW_MAX-1:0]   cnt_q, cnt_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic                 in_valid_q, in_valid_d;
  fifo_entry_t          in_entry_q, in_entry_d;
  logic                 error_q, error_d;
  logic                 overflow_q, overflow_d;
  logic                 out_valid_q, out_valid_d;
  fifo_entry_t          out_entry_q, out_entry_d;
  logic [CNT_WIDTH-1:0] frame_count_q, frame_count_d;

  fifo_entry_t          fifo_head;
  logic                 fifo_full, fifo_empty;
  logic [FIFO_POW:0]    fifo_count;

  logic [FIFO_POW+1:0]  occupancy;
  logic                 out_load, fifo_pop;
  logic                 eligible, has_space, accept, drop;
  logic                 is_sop, is_eop;
  logic [LEN_W-1:0]     len_clamped, frame_len_pow;
  logic [POW_MAX:0]     span;
  logic [POW_MAX-1:0]   last_idx;

  // Accept/drop decision and sop/eop tagging. The staged input sample counts
  // against FIFO capacity so the FIFO write one cycle later can never overflow.
  always_comb begin
    occupancy     = {1'b0, fifo_count} + (FIFO_POW+2)'(in_valid_q);
    out_load      = !out_valid_q || source_ready;
    fifo_pop      = out_load && !fifo_empty;
    eligible      = sink_valid && (enable || (cnt_q != '0));
    has_space     = (!fifo_full && (occupancy < (FIFO_POW+2)'(DEPTH))) || fifo_pop;
    accept        = eligible && has_space;
    drop          = eligible && !has_space;
    len_clamped   = LEN_W'(clamp_pow(int'(len_pow), POW_MIN, POW_MAX));
    is_sop        = (cnt_q == '0);
    frame_len_pow = is_sop ? len_clamped : len_q;
    span          = (POW_MAX+1)'(1) << frame_len_pow;
    last_idx      = POW_MAX'(span - 1'b1);
    is_eop        = (cnt_q == last_idx);
  end

  // Next-state for the write FSM, sample counter and input staging register.
  always_comb begin
    cnt_d      = cnt_q;
    len_d      = len_q;
    in_valid_d = accept;
    in_entry_d = in_entry_q;
    if (accept) begin
      cnt_d          = is_eop ? '0 : cnt_q + 1'b1;
      in_entry_d.sop = is_sop;
      in_entry_d.eop = is_eop;
      in_entry_d.re  = sink_Re;
      in_entry_d.im  = sink_Im;
      if (is_sop) len_d = len_clamped;
    end
    error_d    = drop;
    overflow_d = overflow_q || drop;

    state_d = state_q;
    case (state_q)
      IDLE:     if (enable) state_d = RUN;
      RUN:      if (!enable) state_d = (cnt_d != '0) ? STOPPING : IDLE;
      STOPPING: begin
        if (enable)              state_d = RUN;
        else if (cnt_d == '0)    state_d = IDLE;
      end
      default:  state_d = IDLE;
    endcase
  end

  // Output register loads whenever it is empty or being consumed; frames are
  // counted on the eop handshake.
  always_comb begin
    out_valid_d   = out_load ? !fifo_empty : out_valid_q;
    out_entry_d   = fifo_pop ? fifo_head : out_entry_q;
    frame_count_d = frame_count_q +
                    CNT_WIDTH'(out_valid_q && source_ready && out_entry_q.eop);
  end

  // All framer state registers.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      len_q         <= '0;
      in_valid_q    <= 1'b0;
      in_entry_q    <= '0;
      error_q       <= 1'b0;
      overflow_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      out_entry_q   <= '0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      len_q         <= len_d;
      in_valid_q    <= in_valid_d;
      in_entry_q    <= in_entry_d;
      error_q       <= error_d;
      overflow_q    <= overflow_d;
      out_valid_q   <= out_valid_d;
      out_entry_q   <= out_entry_d;
      frame_count_q <= frame_count_d;
    end
  end

  fft_stream_fifo #(
    .WIDTH     (ENTRY_WIDTH),
    .DEPTH_POW (FIFO_POW)
  ) u_fifo (
    .clk     (clk),
    .rst     (aclr),
    .wr_en   (in_valid_q),
    .wr_data (in_entry_q),
    .rd_en   (fifo_pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign source_valid = out_valid_q;
  assign source_sop   = out_entry_q.sop;
  assign source_eop   = out_entry_q.eop;
  assign source_Re    = out_entry_q.re;
  assign source_Im    = out_entry_q.im;
  assign busy         = (state_q != IDLE);
  assign error        = error_q;
  assign overflow     = overflow_q;
  assign frame_count  = frame_count_q;

endmodule

// File: tb/tb_fft_stream_framer.sv
// Bench for fft_stream_framer: random samples and handshakes against a
// reference model that treats the design as framing rules plus a bounded
// buffer; a separate monitor checks every delivered sample.
module tb_fft_stream_framer;

  localparam int DW  = 14;
  localparam int CAP = (1 << 4) + 1;

  typedef struct packed {
    logic          sop;
    logic          eop;
    logic [DW-1:0] re;
    logic [DW-1:0] im;
  } sample_t;

  logic          clk = 1'b0;
  logic          aclr = 1'b1;
  logic          enable = 1'b0;
  logic [3:0]    len_pow = 4'd6;
  logic          sink_valid = 1'b0;
  logic [DW-1:0] sink_Re = '0;
  logic [DW-1:0] sink_Im = '0;
  logic          source_ready = 1'b0;
  logic          source_valid, source_sop, source_eop;
  logic [DW-1:0] source_Re, source_Im;
  logic          busy, error, overflow;
  logic [15:0]   frame_count;

  int      total = 0;
  int      bad = 0;
  sample_t exp_q[$];
  int      m_cnt, m_len, m_acc, m_del, exp_frames;
  bit      exp_err, exp_busy, exp_ovf, have_exp;
  bit      hold_pending;
  sample_t held, got, e;

  fft_stream_framer dut (
    .clk          (clk),
    .aclr         (aclr),
    .enable       (enable),
    .len_pow      (len_pow),
    .sink_valid   (sink_valid),
    .sink_Re      (sink_Re),
    .sink_Im      (sink_Im),
    .source_ready (source_ready),
    .source_valid (source_valid),
    .source_sop   (source_sop),
    .source_eop   (source_eop),
    .source_Re    (source_Re),
    .source_Im    (source_Im),
    .busy         (busy),
    .error        (error),
    .overflow     (overflow),
    .frame_count  (frame_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int clampLen(input int lp);
    return (lp < 6) ? 6 : ((lp > 12) ? 12 : lp);
  endfunction

  // One clock cycle: check the previous cycle's predictions, drive new inputs,
  // and let the model decide whether this sample enters the design.
  task automatic applyStimulus(input bit en, input int lp, input bit sv, input bit rdy);
    bit hs, eligible, accept, sop, eop;
    @(posedge clk);
    #1;
    if (have_exp) begin
      checkOutput("error", int'(error), int'(exp_err));
      checkOutput("busy", int'(busy), int'(exp_busy));
      checkOutput("overflow", int'(overflow), int'(exp_ovf));
    end
    enable       = en;
    len_pow      = 4'(lp);
    sink_valid   = sv;
    sink_Re      = DW'($urandom);
    sink_Im      = DW'($urandom);
    source_ready = rdy;
    hs       = source_valid && rdy;
    eligible = sv && (en || (m_cnt != 0));
    accept   = eligible && ((m_acc - m_del - int'(hs)) < CAP);
    if (accept) begin
      sop = (m_cnt == 0);
      if (sop) m_len = clampLen(lp);
      eop = (m_cnt == (1 << m_len) - 1);
      exp_q.push_back(sample_t'{sop, eop, sink_Re, sink_Im});
      m_cnt = eop ? 0 : m_cnt + 1;
      m_acc++;
    end
    m_del   += int'(hs);
    exp_err  = eligible && !accept;
    exp_ovf  = exp_ovf || exp_err;
    exp_busy = en || (m_cnt != 0);
    have_exp = 1'b1;
  endtask

  task automatic resetDut();
    @(posedge clk);
    #2;
    aclr = 1'b1;
    #1;
    checkOutput("rst_valid", int'(source_valid), 0);
    checkOutput("rst_flags", int'({source_sop, source_eop}), 0);
    checkOutput("rst_data", int'({source_Re, source_Im}), 0);
    checkOutput("rst_status", int'({busy, error, overflow}), 0);
    checkOutput("rst_frame_count", int'(frame_count), 0);
    exp_q.delete();
    m_cnt = 0; m_len = 6; m_acc = 0; m_del = 0; exp_frames = 0;
    exp_err = 0; exp_busy = 0; exp_ovf = 0; have_exp = 0;
    enable = 1'b0; sink_valid = 1'b0; source_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    aclr = 1'b0;
  endtask

  task automatic alignFrame();
    for (int i = 0; i < 5000 && m_cnt != 0; i++) applyStimulus(1, 6, 1, 1);
  endtask

  // Monitor: compares each handshake against the scoreboard, checks that a
  // stalled output holds steady, and tracks the delivered frame count.
  always @(negedge clk) begin
    if (aclr) begin
      hold_pending = 1'b0;
    end else begin
      got = sample_t'{source_sop, source_eop, source_Re, source_Im};
      checkOutput("frame_count", int'(frame_count), exp_frames & 16'hffff);
      if (hold_pending) begin
        checkOutput("hold_valid", int'(source_valid), 1);
        checkOutput("hold_data", int'(got), int'(held));
      end
      if (source_valid && source_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_output", int'(got), -1);
        end else begin
          e = exp_q.pop_front();
          checkOutput("sample", int'(got), int'(e));
          if (e.eop) exp_frames++;
        end
        hold_pending = 1'b0;
      end else if (source_valid) begin
        hold_pending = 1'b1;
        held         = got;
      end else begin
        hold_pending = 1'b0;
      end
    end
  end

  initial begin
    resetDut();

    // first sample latency: accepted at edge k, visible after edge k+2
    applyStimulus(1, 6, 1, 1);
    applyStimulus(1, 6, 1, 1);
    checkOutput("latency_k1", int'(source_valid), 0);
    applyStimulus(1, 6, 1, 1);
    checkOutput("latency_k2_pre", int'(source_valid), 0);
    applyStimulus(1, 6, 1, 1);
    checkOutput("latency_k2", int'(source_valid), 1);
    checkOutput("first_sop", int'(source_sop), 1);

    // continuous 64-sample framing
    for (int i = 0; i < 200; i++) applyStimulus(1, 6, 1, 1);
    $display("[TB] continuous framing phase done");

    // 4096 frame latched, then mid-frame change to 6 ignored until next sop
    alignFrame();
    for (int i = 0; i < 4200; i++) applyStimulus(1, (i < 50) ? 12 : 6, 1, 1);

    // clamping below and above the supported range
    alignFrame();
    for (int i = 0; i < 130; i++) applyStimulus(1, 2, 1, 1);
    for (int i = 0; i < 4200; i++) applyStimulus(1, 15, 1, 1);
    $display("[TB] length and clamp phases done");

    // sink stall with continuous input: drops, error pulses, sticky overflow
    alignFrame();
    for (int i = 0; i < 30; i++) applyStimulus(1, 6, 1, 0);
    checkOutput("overflow_sticky", int'(overflow), 1);
    for (int i = 0; i < 150; i++) applyStimulus(1, 6, 1, 1);

    // enable dropped at sample 10: frame completes, then idle
    alignFrame();
    for (int i = 0; i < 10; i++) applyStimulus(1, 6, 1, 1);
    for (int i = 0; i < 70; i++) applyStimulus(0, 6, 1, 1);
    checkOutput("stopped_busy", int'(busy), 0);
    // enable re-raised during STOPPING
    for (int i = 0; i < 10; i++) applyStimulus(1, 6, 1, 1);
    for (int i = 0; i < 20; i++) applyStimulus(0, 6, 1, 1);
    for (int i = 0; i < 100; i++) applyStimulus(1, 6, 1, 1);
    $display("[TB] stall and stop phases done");

    // random handshakes, enables and lengths
    for (int i = 0; i < 3000; i++)
      applyStimulus($urandom_range(0, 99) < 95, $urandom_range(0, 15),
                    $urandom_range(0, 99) < 80, $urandom_range(0, 1) == 1);

    // asynchronous reset in the middle of a packet
    for (int i = 0; i < 20; i++) applyStimulus(1, 6, 1, 1);
    resetDut();
    for (int i = 0; i < 100; i++) applyStimulus(1, 6, 1, 1);

    // drain
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) applyStimulus(0, 6, 0, 1);
    applyStimulus(0, 6, 0, 1);
    checkOutput("drain_empty", exp_q.size(), 0);
    checkOutput("all_delivered", m_del, m_acc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
